// File: rtl/psum_adder.sv
// psum_adder: gathers one signed partial sum per PE lane, reduces them and emits the
// per-pixel result with its address to output memory. Build option PSUM_RELU_EN clamps negative results to 0.

module psum_lane #(
   parameter int DW = 8,
   parameter int OW = DW + 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          clr,
   input  logic          valid,
   input  logic [DW-1:0] data,
   output logic          ready,
   output logic          got,
   output logic [OW-1:0] nxt
);
   logic [OW-1:0] cap;
   logic [OW-1:0] ext;
   logic          xfer;

   assign ext   = {{(OW-DW){data[DW-1]}}, data};
   assign ready = en & ~got;
   assign xfer  = valid & ready;
   // what this lane contributes if the pixel completes on the coming edge
   assign nxt   = xfer ? ext : cap;

   always_ff @(posedge clk) begin
      if (reset) begin
         got <= 1'b0;
         cap <= '0;
      end else if (clr) begin
         got <= 1'b0;
      end else if (xfer) begin
         got <= 1'b1;
         cap <= ext;
      end
   end
endmodule

module psum_adder #(
   parameter int NUM_IN    = 3,
   parameter int DW        = 8,
   parameter int OW        = DW + 2,
   parameter int OUT_COUNT = 9
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_valid,
   output logic                 start_ready,
   input  logic [NUM_IN-1:0]    psum_valid,
   output logic [NUM_IN-1:0]    psum_ready,
   input  logic [NUM_IN*DW-1:0] psum_data,
   output logic                 sum_valid,
   input  logic                 sum_ready,
   output logic [OW-1:0]        sum_data,
   output logic [3:0]           sum_addr,
   output logic                 done_valid,
   input  logic                 done_ready
);
   typedef enum logic [1:0] {S_IDLE, S_GATHER, S_EMIT, S_DONE} state_t;

   typedef struct packed {
      logic [OW-1:0] data;
      logic [3:0]    addr;
   } sum_rsp_t;

   localparam logic [3:0] LAST = 4'(OUT_COUNT - 1);

   state_t                       state;
   logic [3:0]                   count;
   sum_rsp_t                     rsp_q;
   logic                         gather;
   logic                         clr;
   logic                         all_in;
   logic [NUM_IN-1:0]            got;
   logic [NUM_IN-1:0][OW-1:0]    nxt;
   logic signed [OW-1:0]         acc;
   logic [OW-1:0]                res;

   assign gather = (state == S_GATHER);
   // lane flags are cleared when a run starts and when a result leaves
   assign clr    = ((state == S_IDLE) & start_valid) | ((state == S_EMIT) & sum_ready);
   assign all_in = gather & (&(got | (psum_valid & psum_ready)));

   for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
      psum_lane #(.DW(DW), .OW(OW)) u_lane (
         .clk   (clk),
         .reset (reset),
         .en    (gather),
         .clr   (clr),
         .valid (psum_valid[g]),
         .data  (psum_data[g*DW +: DW]),
         .ready (psum_ready[g]),
         .got   (got[g]),
         .nxt   (nxt[g])
      );
   end

   always_comb begin
      acc = '0;
      for (int i = 0; i < NUM_IN; i++) acc = acc + $signed(nxt[i]);
   end

`ifdef PSUM_RELU_EN
   assign res = acc[OW-1] ? '0 : acc;
`else
   assign res = acc;
`endif

   assign sum_data = rsp_q.data;
   assign sum_addr = rsp_q.addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         count       <= '0;
         start_ready <= 1'b1;
         sum_valid   <= 1'b0;
         rsp_q       <= '0;
         done_valid  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_valid) begin
                  state       <= S_GATHER;
                  count       <= '0;
                  start_ready <= 1'b0;
               end
            end
            S_GATHER: begin
               if (all_in) begin
                  sum_valid  <= 1'b1;
                  rsp_q.data <= res;
                  rsp_q.addr <= count;
                  state      <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (sum_ready) begin
                  sum_valid <= 1'b0;
                  if (count == LAST) begin
                     state      <= S_DONE;
                     done_valid <= 1'b1;
                  end else begin
                     count <= count + 4'd1;
                     state <= S_GATHER;
                  end
               end
            end
            S_DONE: begin
               if (done_ready) begin
                  done_valid  <= 1'b0;
                  count       <= '0;
                  state       <= S_IDLE;
                  start_ready <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
